// File: rtl/ysyx_22040386_muldiv_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier, restoring divider.
// Optional MULDIV_EARLY_OUT_EN: MUL stops once the remaining multiplier bits are all zero.
module ysyx_22040386_muldiv_iter #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            word_op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int unsigned H = XLEN / 2;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   function automatic logic [XLEN-1:0] sext_h(input logic [H-1:0] v);
      return {{H{v[H-1]}}, v};
   endfunction

   function automatic logic [XLEN-1:0] zext_h(input logic [H-1:0] v);
      return {{H{1'b0}}, v};
   endfunction

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic              word_q, word_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;       // product, or {remainder, quotient}
   logic [XLEN-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [XLEN-1:0]   result_q, result_d;

   // Accept-time operand decode
   logic [2:0]        a_op;
   logic              a_s1, a_s2, a_neg1, a_neg2, a_dz, a_ovf;
   logic [XLEN-1:0]   a_x, a_y, a_mag1, a_mag2, a_min, a_dvd;

   always_comb begin
      a_op   = (word_op && !op[2]) ? 3'd0 : op;
      a_s1   = a_op inside {3'd1, 3'd2, 3'd4, 3'd6};
      a_s2   = a_op inside {3'd1, 3'd4, 3'd6};
      a_x    = word_op ? (a_s1 ? sext_h(src1[H-1:0]) : zext_h(src1[H-1:0])) : src1;
      a_y    = word_op ? (a_s2 ? sext_h(src2[H-1:0]) : zext_h(src2[H-1:0])) : src2;
      a_neg1 = a_s1 && a_x[XLEN-1];
      a_neg2 = a_s2 && a_y[XLEN-1];
      a_mag1 = a_neg1 ? -a_x : a_x;
      a_mag2 = a_neg2 ? -a_y : a_y;
      a_min  = word_op ? sext_h({1'b1, {(H-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
      a_dz   = a_op[2] && (a_y == '0);
      a_ovf  = a_op[2] && a_s2 && (a_x == a_min) && (a_y == '1);
      // Left-align the dividend so the first quotient bit is always acc[XLEN-1]
      a_dvd  = word_op ? {a_mag1[H-1:0], {H{1'b0}}} : a_mag1;
   end

   // Iteration datapath
   logic [CNT_W-1:0]  n_cur;
   logic              last, mul_fin, div_ge;
   logic [XLEN:0]     mul_sum, div_rs, div_diff;
   logic [2*XLEN-1:0] mul_step, mul_prod, mul_sgn;
   logic [XLEN-1:0]   mul_res, div_rem, div_quo, div_val, div_sgn, div_res;

   always_comb begin
      n_cur    = word_q ? CNT_W'(H) : CNT_W'(XLEN);
      last     = (cnt_q == n_cur - CNT_W'(1));
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q & {XLEN{mplier_q[0]}}};
      mul_step = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
      mul_fin  = last || (mplier_q[XLEN-1:1] == '0);
      mul_prod = mul_step >> (n_cur - cnt_q - CNT_W'(1));
`else
      mul_fin  = last;
      mul_prod = mul_step;
`endif
      // A word product lands H bits up, since only N of the XLEN right shifts happen
      mul_sgn  = neg_res_q ? -mul_prod : mul_prod;
      if (word_q) begin
         mul_res = sext_h(mul_sgn[H +: H]);
      end else if (op_q == 3'd0) begin
         mul_res = mul_sgn[XLEN-1:0];
      end else begin
         mul_res = mul_sgn[2*XLEN-1:XLEN];
      end

      div_rs   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = div_rs - {1'b0, opb_q};
      div_ge   = !div_diff[XLEN];
      div_rem  = div_ge ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
      div_quo  = {acc_q[XLEN-2:0], div_ge};
      div_val  = op_q[1] ? div_rem : div_quo;
      div_sgn  = (op_q[1] ? neg_rem_q : neg_res_q) ? -div_val : div_val;
      div_res  = word_q ? sext_h(div_sgn[H-1:0]) : div_sgn;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      word_d    = word_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      mplier_d  = mplier_q;
      result_d  = result_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               op_d      = a_op;
               word_d    = word_op;
               neg_res_d = a_neg1 ^ a_neg2;
               neg_rem_d = a_neg1;
               cnt_d     = '0;
               opb_d     = a_op[2] ? a_mag2 : a_mag1;
               mplier_d  = a_mag2;
               acc_d     = a_op[2] ? {{XLEN{1'b0}}, a_dvd} : '0;
               if (a_dz) begin
                  result_d = a_op[1] ? (word_op ? sext_h(src1[H-1:0]) : src1) : '1;
                  state_d  = StDone;
               end else if (a_ovf) begin
                  result_d = a_op[1] ? '0 : a_x;
                  state_d  = StDone;
               end else begin
                  state_d = a_op[2] ? StDiv : StMul;
               end
            end
         end
         StMul: begin
            acc_d    = mul_step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_fin) begin
               result_d = mul_res;
               state_d  = StDone;
            end
         end
         StDiv: begin
            acc_d = {div_rem, div_quo};
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               result_d = div_res;
               state_d  = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d  = StIdle;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= '0;
         word_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         mplier_q  <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         word_q    <= word_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         mplier_q  <= mplier_d;
         result_q  <= result_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040386_muldiv_iter.sv
// Randomised and directed bench for ysyx_22040386_muldiv_iter against a plain-arithmetic model.
module tb_ysyx_22040386_muldiv_iter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic        word_op = 1'b0;
   logic [63:0] src1 = '0;
   logic [63:0] src2 = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] result;
   logic        busy;

   int          errs = 0;
   int          checks = 0;
   string       ctx = "reset";
   logic [63:0] last_res = '0;

   ysyx_22040386_muldiv_iter #(.XLEN(64), .CNT_W(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word_op   (word_op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s [%s]: got %h expected %h", tag, ctx, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [127:0]       pa, pb, pr;
      logic signed [63:0] sa, sb, sq;
      logic signed [31:0] wa, wb, wq;
      logic [31:0]        r32;
      logic [63:0]        r;
      r = '0;
      if (w) begin
         wa = a[31:0];
         wb = b[31:0];
         if (!o[2]) begin
            r32 = a[31:0] * b[31:0];
         end else if (o[0]) begin
            if (b[31:0] == 32'd0) r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (o[1]) r32 = a[31:0] % b[31:0];
            else r32 = a[31:0] / b[31:0];
         end else begin
            if (wb == 32'sd0) r32 = o[1] ? a[31:0] : 32'hFFFF_FFFF;
            else if (wa == 32'sh8000_0000 && wb == -32'sd1) r32 = o[1] ? 32'd0 : a[31:0];
            else begin
               if (o[1]) wq = wa % wb;
               else wq = wa / wb;
               r32 = wq;
            end
         end
         r = {{32{r32[31]}}, r32};
      end else begin
         case (o)
            3'd0: r = a * b;
            3'd1: begin
               pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; pr = pa * pb; r = pr[127:64];
            end
            3'd2: begin
               pa = {{64{a[63]}}, a}; pb = {64'd0, b}; pr = pa * pb; r = pr[127:64];
            end
            3'd3: begin
               pa = {64'd0, a}; pb = {64'd0, b}; pr = pa * pb; r = pr[127:64];
            end
            3'd4, 3'd6: begin
               sa = a;
               sb = b;
               if (b == 64'd0) r = o[1] ? a : '1;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = o[1] ? 64'd0 : a;
               else begin
                  if (o[1]) sq = sa % sb;
                  else sq = sa / sb;
                  r = sq;
               end
            end
            default: begin
               if (b == 64'd0) r = o[1] ? a : '1;
               else if (o[1]) r = a % b;
               else r = a / b;
            end
         endcase
      end
      return r;
   endfunction

   // Cycles from the accepting edge (counted as 1) until out_valid is seen
   function automatic int exp_lat(input logic [2:0] o, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      int          n;
      logic        sg;
      logic [63:0] x, y, m;
      n = w ? 32 : 64;
      if (o[2]) begin
         sg = !o[0];
         x  = w ? (sg ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
         y  = w ? (sg ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
         if (y == 64'd0) return 1;
         if (sg && y == '1 && x == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000))
            return 1;
         return n + 1;
      end
`ifdef MULDIV_EARLY_OUT_EN
      if (w) m = {32'd0, b[31:0]};
      else if (o == 3'd1 && b[63]) m = -b;
      else m = b;
      for (int k = n - 1; k >= 0; k--) if (m[k]) return k + 2;
      return 2;
`else
      m = b;
      return n + 1 + int'(m[0] & 1'b0);
`endif
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 7))
         0: return 64'd0;
         1: return 64'd1;
         2: return '1;
         3: return 64'h8000_0000_0000_0000;
         4: return {32'($urandom()), 32'h8000_0000};
         5: return 64'($urandom_range(0, 40));
         6: return {32'($urandom()), 32'($urandom_range(0, 9))};
         default: return {32'($urandom()), 32'($urandom())};
      endcase
   endfunction

   task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int hold);
      logic [63:0] exp;
      int          lat;
      int          want;
      exp  = model(o, w, a, b);
      want = exp_lat(o, w, a, b);
      ctx  = $sformatf("op=%0d w=%0d a=%h b=%h", o, w, a, b);
      @(negedge clk);
      check("idle_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; word_op = w; src1 = a; src2 = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check("out_valid", 64'(out_valid), 64'd1);
      check("result", result, exp);
      check("latency", 64'(lat), 64'(want));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_result", result, exp);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("leave_in_ready", 64'(in_ready), 64'd1);
      check("leave_valid", 64'(out_valid), 64'd0);
      last_res = exp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      do_op(3'd0, 1'b0, 64'h7, 64'h6, 0);
      do_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
      do_op(3'd2, 1'b0, '1, '1, 0);
      do_op(3'd4, 1'b0, -64'd7, 64'd2, 10);
      do_op(3'd6, 1'b0, -64'd7, 64'd2, 0);
      do_op(3'd4, 1'b1, 64'h0000_0001_0000_0010, 64'd4, 0);
      do_op(3'd5, 1'b0, 64'd5, 64'd0, 0);
      do_op(3'd7, 1'b0, 64'd5, 64'd0, 0);
      do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
      do_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
      do_op(3'd3, 1'b0, 64'd1, 64'd1, 0);
      do_op(3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, 0);

      // flush beats in_valid while idle
      ctx = "flush_idle";
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = 3'd0; src1 = 64'd3; src2 = 64'd3;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_busy", 64'(busy), 64'd0);
      check("flush_idle_in_ready", 64'(in_ready), 64'd1);

      // flush in the middle of a DIV
      ctx = "flush_div";
      @(negedge clk);
      in_valid = 1'b1; op = 3'd5; word_op = 1'b0; src1 = 64'd1000; src2 = 64'd7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      check("flush_div_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_div_in_ready", 64'(in_ready), 64'd1);
      check("flush_div_valid", 64'(out_valid), 64'd0);
      check("flush_div_result_kept", result, last_res);
      repeat (70) begin
         @(posedge clk); #1;
         if (out_valid) check("flush_div_spurious_valid", 64'(out_valid), 64'd0);
      end
      do_op(3'd0, 1'b0, 64'd3, 64'd3, 0);

      // Random operations
      for (int t = 0; t < 80; t++) begin
         do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(), 0);
      end

      // Asynchronous reset mid-MUL
      ctx = "rst_mid_mul";
      @(negedge clk);
      in_valid = 1'b1; op = 3'd0; word_op = 1'b0; src1 = 64'd3; src2 = 64'h8000_0000_0000_0005;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      check("rst_mid_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd1);
      check("rst_mid_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      do_op(3'd0, 1'b0, 64'd3, 64'd3, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22040386_muldiv_iter.md
Name: ysyx_22040386_muldiv_iter

Overview:
Parametrised, multi-cycle RV64M multiply/divide unit for the NPC execute stage, with valid/ready handshakes on both sides. It replaces single-cycle "*", "/" and "%" datapaths with a radix-2 shift-add multiplier and a restoring divider. It covers the full M set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus W forms) and applies RISC-V divide-by-zero and overflow semantics. One operation is in flight at a time; flush is supported for pipeline redirects.

Parameters:
XLEN, 64, datapath width; must be even, and word ops use XLEN/2.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  unit can accept; high only in IDLE
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
word_op  input  1  W-form: operate on low XLEN/2 bits, sign-extend result
src1  input  XLEN  rs1 (multiplicand / dividend)
src2  input  XLEN  rs2 (multiplier / divisor)
flush  input  1  abort current op, synchronous
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  final result, held stable while out_valid && !out_ready
busy  output  1  high in MUL, DIV or DONE

Behaviour:
- States: IDLE, MUL, DIV, DONE. Reset: IDLE, out_valid=0, result=0, busy=0, in_ready=1, counter=0, all datapath regs 0.
- Accept on in_valid && in_ready: latch op, word_op, operands and sign flags. Go to MUL (op<4) or DIV (op>=4).
- Width N = XLEN/2 if word_op else XLEN. With word_op, operands are the low N bits; signed ops sign-extend them and unsigned ops zero-extend them.
- word_op with op 1..3 executes as MUL (MULW); no illegal-op signalling.
- Signed handling: take magnitudes of the signed operands (MULH both, MULHSU src1 only, DIV/REM both). Negate the final product/quotient if the operand signs differ; negate the remainder if the dividend is negative.
- MUL: 2N-bit product register, one multiplier bit per cycle, N cycles. MUL returns the low N bits; MULH* return the high N bits. Sign-extend when word_op.
- DIV: restoring, one quotient bit per cycle, N cycles.
- Divide by zero detected at accept: go directly to DONE next cycle. Quotient = all ones (N bits, sign-extended). Remainder = dividend (N bits, sign-extended).
- Signed overflow (dividend = most-negative N-bit, divisor = -1) detected at accept: go to DONE next cycle. Quotient = dividend; remainder = 0.
- Latency, accept edge to out_valid: N+1 cycles normally, 1 cycle for the special cases. For XLEN=64: 65 cycles (64-bit), 33 cycles (W).
- DONE: out_valid=1, result registered. Leave to IDLE on out_ready. in_ready is not asserted in the same cycle; there is no same-cycle re-accept.
- flush in any state: next state IDLE, out_valid=0, result retains its last value, partial state discarded. flush wins over in_valid and out_ready in the same cycle.
- rst asserted mid-operation: immediately returns to reset values.
- in_valid while not in_ready: ignored; the requester must hold it.

Optional Feature:
Macro: MULDIV_EARLY_OUT_EN.
- Defined: MUL finishes as soon as the remaining unshifted multiplier bits are all zero. It shifts the product by the remaining count in one step and enters DONE next cycle. Minimum MUL latency is 2 cycles (multiplier 0 or 1); results are identical.
- Undefined: MUL always takes exactly N iterations. DIV is unaffected either way.

Test Plan:
- MUL src1=0x7, src2=0x6, word_op=0 -> out_valid after 65 cycles, result=0x2A; with MULDIV_EARLY_OUT_EN -> within 4 cycles, same result.
- MULH src1=0x8000000000000000, src2=0x8000000000000000 -> result=0x4000000000000000; MULHSU src1=-1, src2=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFF.
- DIV src1=-7, src2=2 -> result=0xFFFFFFFFFFFFFFFD (-3); REM same operands -> 0xFFFFFFFFFFFFFFFF (-1); DIVW src1=0x0000000100000010, src2=4 -> 0x4, latency 33 cycles.
- DIVU src1=5, src2=0 -> 1-cycle latency, result=0xFFFFFFFFFFFFFFFF; REMU same -> 5; DIV src1=0x8000000000000000, src2=-1 -> result=0x8000000000000000; REM same -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
- Assert flush at cycle 20 of a DIV -> IDLE next cycle, no out_valid; a new MUL 3*3 then returns 9. Assert rst mid-MUL -> all outputs at reset values immediately.
